// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing with mem_ready handshake and timeout-to-HALT.
// Optional `MC_PERF_CNT_EN adds cyc_cnt/instret_cnt performance counters.
module multi_cycle_control_unit #(
  parameter int OP_W        = 6,
  parameter int FUNC_W      = 6,
  parameter int MEM_TIMEOUT = 16
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   OP,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  input  logic              sign,
  input  logic              mem_ready,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              DBDataSrc,
  output logic              RegDst,
  output logic              ExtSel,
  output logic              RegWre,
  output logic              mRD,
  output logic              mWR,
  output logic [2:0]        ALUOp,
  output logic [1:0]        PCSrc,
  output logic [2:0]        state,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  instret_cnt,
`endif
  output logic              err
);

  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010, S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b101
  } state_t;

  localparam logic [OP_W-1:0] OPC_R     = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OPC_ADDIU = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OPC_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OPC_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OPC_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OPC_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OPC_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OPC_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OPC_BLTZ  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OPC_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OPC_HALT  = OP_W'(6'b111111);

  localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(6'b101010);
  localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(6'b000000);

  // Wide enough to hold MEM_TIMEOUT-1; a limit of 0 disables the timeout entirely.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic is_r, is_imm, is_lw, is_sw, is_br, is_j, is_halt, known, taken, waiting, timeout;
  logic alu_src_a, alu_src_b, db_src, reg_dst, ext_sel;
  logic [2:0] alu_op;

  always_comb begin
    is_r = 1'b0; is_imm = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_br = 1'b0; is_j = 1'b0; is_halt = 1'b0; taken = 1'b0;
    alu_src_a = 1'b0; alu_src_b = 1'b0; db_src = 1'b0; reg_dst = 1'b0; ext_sel = 1'b0;
    alu_op = 3'b000;
    case (OP)
      OPC_R: begin
        is_r = 1'b1; reg_dst = 1'b1;
        case (func)
          F_ADD:   alu_op = 3'b000;
          F_SUB:   alu_op = 3'b001;
          F_SLL:   begin alu_op = 3'b010; alu_src_a = 1'b1; end
          F_OR:    alu_op = 3'b011;
          F_AND:   alu_op = 3'b100;
          F_SLT:   alu_op = 3'b110;
          default: alu_op = 3'b000;
        endcase
      end
      OPC_ADDIU: begin is_imm = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; end
      OPC_ANDI:  begin is_imm = 1'b1; alu_src_b = 1'b1; alu_op = 3'b100; end
      OPC_ORI:   begin is_imm = 1'b1; alu_src_b = 1'b1; alu_op = 3'b011; end
      OPC_SLTI:  begin is_imm = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = 3'b110; end
      OPC_LW:    begin is_lw = 1'b1; alu_src_b = 1'b1; db_src = 1'b1; ext_sel = 1'b1; end
      OPC_SW:    begin is_sw = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; end
      OPC_BEQ:   begin is_br = 1'b1; ext_sel = 1'b1; alu_op = 3'b001; taken = zero; end
      OPC_BNE:   begin is_br = 1'b1; ext_sel = 1'b1; alu_op = 3'b001; taken = ~zero; end
      OPC_BLTZ:  begin is_br = 1'b1; ext_sel = 1'b1; alu_op = 3'b001; taken = sign; end
      OPC_J:     is_j = 1'b1;
      OPC_HALT:  is_halt = 1'b1;
      default:   ;
    endcase
    known = is_r | is_imm | is_lw | is_sw | is_br | is_j | is_halt;
  end

  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIM);

  always_comb begin
    state_d = state_q; wait_d = '0; err_d = err_q; waiting = 1'b0;
    PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWre = 1'b0;
    mRD = 1'b0; mWR = 1'b0; PCSrc = 2'b00;
    ALUSrcA = alu_src_a; ALUSrcB = alu_src_b; DBDataSrc = db_src;
    RegDst = reg_dst; ExtSel = ext_sel; ALUOp = alu_op;
    state = state_q; err = err_q;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        if (mem_ready) begin IRWre = 1'b1; state_d = S_ID; end
        else waiting = 1'b1;
      end
      S_ID: begin
        if (is_j)          begin PCWre = 1'b1; PCSrc = 2'b10; state_d = S_IF; end
        else if (is_halt)  state_d = S_HALT;
        else if (!known)   begin PCWre = 1'b1; state_d = S_IF; end
        else               state_d = S_EXE;
      end
      S_EXE: begin
        if (is_br)              begin PCWre = 1'b1; PCSrc = taken ? 2'b01 : 2'b00; state_d = S_IF; end
        else if (is_lw | is_sw) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM: begin
        mRD = is_lw; mWR = is_sw;
        if (mem_ready) begin
          if (is_lw) state_d = S_WB;
          else begin PCWre = 1'b1; state_d = S_IF; end
        end else waiting = 1'b1;
      end
      S_WB: begin RegWre = 1'b1; PCWre = 1'b1; state_d = S_IF; end
      S_HALT: ;
      default: state_d = S_IF;
    endcase
    // A ready arriving on the limit cycle is not waiting, so it never trips the timeout.
    if (waiting) begin
      if (timeout) begin state_d = S_HALT; err_d = 1'b1; end
      else wait_d = wait_q + 1'b1;
    end
    if (RST) begin
      state_d = S_IF; wait_d = '0; err_d = 1'b0;
      PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; RegWre = 1'b0; mRD = 1'b0; mWR = 1'b0;
      PCSrc = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 1'b0; DBDataSrc = 1'b0; RegDst = 1'b0;
      ExtSel = 1'b0; ALUOp = 3'b000; state = S_IF; err = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IF;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, instret_q, instret_d;

  always_comb begin
    cyc_d     = cyc_q + ((state_q != S_HALT) ? CNT_W'(1) : CNT_W'(0));
    instret_d = instret_q + (PCWre ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_q     <= '0;
      instret_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      instret_q <= instret_d;
    end
  end

  assign cyc_cnt     = RST ? '0 : cyc_q;
  assign instret_cnt = RST ? '0 : instret_q;
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: directed spec scenarios plus random instruction streams
// checked every cycle against a phase-list model of each instruction class.
module tb_multi_cycle_control_unit;
  localparam int T = 4;

  localparam logic [5:0] O_R = 6'b000000, O_ADDIU = 6'b001001, O_ANDI = 6'b001100,
    O_ORI = 6'b001101, O_SLTI = 6'b001010, O_LW = 6'b100011, O_SW = 6'b101011,
    O_BEQ = 6'b000100, O_BNE = 6'b000101, O_BLTZ = 6'b000001, O_J = 6'b000010,
    O_HALT = 6'b111111, O_BAD = 6'b010000;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
    F_OR = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000;

  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_J = 4, C_HLT = 5, C_NOP = 6;

  logic CLK = 1'b0, RST = 1'b1;
  logic [5:0] OP = O_R, func = F_ADD;
  logic zero = 1'b0, sign = 1'b0, mem_ready = 1'b1;
  logic PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel, RegWre, mRD, mWR, err;
  logic [2:0] ALUOp, state;
  logic [1:0] PCSrc;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, instret_cnt;
`endif

  multi_cycle_control_unit #(.OP_W(6), .FUNC_W(6), .MEM_TIMEOUT(T)
`ifdef MC_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .OP(OP), .func(func), .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .RegDst(RegDst), .ExtSel(ExtSel), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state),
`ifdef MC_PERF_CNT_EN
    .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt),
`endif
    .err(err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int m_pos = 0, m_wait = 0;
  bit m_halt = 1'b0, m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      O_R, O_ADDIU, O_ANDI, O_ORI, O_SLTI: return C_ALU;
      O_LW: return C_LD;
      O_SW: return C_ST;
      O_BEQ, O_BNE, O_BLTZ: return C_BR;
      O_J: return C_J;
      O_HALT: return C_HLT;
      default: return C_NOP;
    endcase
  endfunction

  // Phases an instruction of each class walks through, IF first.
  function automatic int len_of(input int c);
    case (c)
      C_BR: return 3;
      C_ALU, C_ST: return 4;
      C_LD: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int phase_at(input int c, input int idx);
    case (idx)
      0: return P_IF;
      1: return P_ID;
      2: return P_EXE;
      3: return (c == C_ALU) ? P_WB : P_MEM;
      default: return P_WB;
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel, ALUOp}
  function automatic logic [7:0] sel_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      O_R: case (fn)
        F_SUB: return 8'b0_0_0_1_0_001;
        F_SLL: return 8'b1_0_0_1_0_010;
        F_OR:  return 8'b0_0_0_1_0_011;
        F_AND: return 8'b0_0_0_1_0_100;
        F_SLT: return 8'b0_0_0_1_0_110;
        default: return 8'b0_0_0_1_0_000;
      endcase
      O_ADDIU: return 8'b0_1_0_0_1_000;
      O_ANDI:  return 8'b0_1_0_0_0_100;
      O_ORI:   return 8'b0_1_0_0_0_011;
      O_SLTI:  return 8'b0_1_0_0_1_110;
      O_LW:    return 8'b0_1_1_0_1_000;
      O_SW:    return 8'b0_1_0_0_1_000;
      O_BEQ, O_BNE, O_BLTZ: return 8'b0_0_0_0_1_001;
      default: return 8'b0;
    endcase
  endfunction

  always @(negedge CLK) begin : cmp
    logic [19:0] act, exp;
    logic [7:0] sel;
    logic [1:0] pcs;
    int ph, c;
    bit wt, last, pcw, tk;
    cyc++;
    act = {state, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, PCSrc,
           ALUSrcA, ALUSrcB, DBDataSrc, RegDst, ExtSel, ALUOp, err};
    if (RST) begin
      exp = '0;
      m_pos = 0; m_wait = 0; m_halt = 1'b0; m_err = 1'b0;
    end else begin
      sel = sel_of(OP, func);
      c = cls_of(OP);
      if (m_halt) begin
        exp = {3'(P_HALT), 6'b0, 2'b0, sel, m_err};
      end else begin
        ph = phase_at(c, m_pos);
        wt = (ph == P_IF || ph == P_MEM) && !mem_ready;
        last = (m_pos == len_of(c) - 1);
        pcw = !wt && last && (c != C_HLT);
        tk = (OP == O_BEQ && zero) || (OP == O_BNE && !zero) || (OP == O_BLTZ && sign);
        pcs = !pcw ? 2'b00 : (c == C_J) ? 2'b10 : (c == C_BR && tk) ? 2'b01 : 2'b00;
        exp = {3'(ph), pcw, (ph == P_IF) && mem_ready, ph == P_IF, ph == P_WB,
               (ph == P_MEM) && (c == C_LD), (ph == P_MEM) && (c == C_ST), pcs, sel, m_err};
        if (wt) begin
          m_wait++;
          if (m_wait == T) begin m_halt = 1'b1; m_err = 1'b1; end
        end else begin
          m_wait = 0;
          if (!last) m_pos++;
          else if (c == C_HLT) m_halt = 1'b1;
          else m_pos = 0;
        end
      end
    end
    chk($sformatf("outputs@cyc%0d", cyc), 32'(act), 32'(exp));
  end

  task automatic step(input bit r, input logic [5:0] o, input logic [5:0] f,
                      input bit rdy, input bit z, input bit s);
    @(posedge CLK); #1;
    RST = r; OP = o; func = f; mem_ready = rdy; zero = z; sign = s;
    @(negedge CLK); #1;
  endtask

  initial begin
    logic [5:0] r_op, r_fn;
    int ncyc, nrd, hc, k;
    bit r;
    // reset with mem_ready high: nothing enabled
    step(1, O_R, F_ADD, 1, 0, 0);
    chk("rst_en", 32'({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}), 32'h0);
    step(1, O_R, F_ADD, 1, 0, 0);
    chk("rst_state", 32'(state), 32'h0);
    // add: IF ID EXE WB
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("add_if_state", 32'(state), 32'h0);
    chk("add_if_insmem", 32'(InsMemRW), 32'h1);
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("add_id_state", 32'(state), 32'h1);
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("add_exe", 32'({state, RegWre, PCWre, ALUOp}), 32'({3'd2, 1'b0, 1'b0, 3'd0}));
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("add_wb", 32'({state, RegWre, PCWre}), 32'({3'd4, 1'b1, 1'b1}));
    // lw with three not-ready cycles in MEM
    ncyc = 0; nrd = 0;
    for (int n = 0; n < 20; n++) begin
      step(0, O_LW, 6'd0, !(n >= 3 && n <= 5), 0, 0);
      if (mRD) nrd++;
      if (state == 3'd4) chk("lw_wb_dbsrc", 32'(DBDataSrc), 32'h1);
      if (PCWre) begin ncyc = n + 1; break; end
    end
    chk("lw_cycles", 32'(ncyc), 32'd8);
    chk("lw_mrd_cycles", 32'(nrd), 32'd4);
    // beq taken, bne not taken, j
    for (int n = 0; n < 3; n++) step(0, O_BEQ, 6'd0, 1, 1, 0);
    chk("beq_exe", 32'({PCWre, PCSrc}), 32'({1'b1, 2'b01}));
    for (int n = 0; n < 3; n++) step(0, O_BNE, 6'd0, 1, 1, 0);
    chk("bne_exe", 32'({PCWre, PCSrc}), 32'({1'b1, 2'b00}));
    step(0, O_J, 6'd0, 1, 0, 0);
    step(0, O_J, 6'd0, 1, 0, 0);
    chk("j_id", 32'({state, PCWre, PCSrc}), 32'({3'd1, 1'b1, 2'b10}));
    // ready on the limit cycle wins
    for (int n = 0; n < T - 1; n++) step(0, O_J, 6'd0, 0, 0, 0);
    step(0, O_J, 6'd0, 1, 0, 0);
    chk("limit_ready_irwre", 32'(IRWre), 32'h1);
    step(0, O_J, 6'd0, 1, 0, 0);
    chk("limit_ready_id", 32'({state, err}), 32'({3'd1, 1'b0}));
    // IF timeout
    for (int n = 0; n < T; n++) step(0, O_R, F_ADD, 0, 0, 0);
    chk("to_last_if", 32'({state, InsMemRW, err}), 32'({3'd0, 1'b1, 1'b0}));
    step(0, O_R, F_ADD, 0, 0, 0);
    chk("to_halt", 32'({state, err}), 32'({3'd5, 1'b1}));
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("to_halt_sticky", 32'({state, err, PCWre, InsMemRW}), 32'({3'd5, 1'b1, 1'b0, 1'b0}));
    step(1, O_R, F_ADD, 1, 0, 0);
    chk("to_rst", 32'({state, err}), 32'h0);
    step(0, O_R, F_ADD, 1, 0, 0);
    chk("to_recover", 32'({state, InsMemRW, err}), 32'({3'd0, 1'b1, 1'b0}));
`ifdef MC_PERF_CNT_EN
    step(1, O_R, F_ADD, 1, 0, 0);
    for (int n = 0; n < 4; n++) step(0, O_R, F_ADD, 1, 0, 0);
    for (int n = 0; n < 2; n++) step(0, O_J, 6'd0, 1, 0, 0);
    for (int n = 0; n < 5; n++) step(0, O_HALT, 6'd0, 1, 0, 0);
    chk("perf_instret", instret_cnt, 32'd2);
    chk("perf_cyc", cyc_cnt, 32'd8);
    step(1, O_R, F_ADD, 1, 0, 0);
`endif
    // random instruction streams
    r_op = OP; r_fn = func; hc = 0;
    for (int i = 0; i < 3000; i++) begin
      hc = m_halt ? hc + 1 : 0;
      r = (hc >= 2) || ($urandom_range(0, 299) == 0);
      if (m_pos == 0 && !m_halt) begin
        k = $urandom_range(0, 20);
        r_fn = 6'($urandom_range(0, 63));
        case (k)
          0: r_fn = F_ADD; 1: r_fn = F_SUB; 2: r_fn = F_AND; 3: r_fn = F_OR;
          4: r_fn = F_SLT; 5: r_fn = F_SLL; default: ;
        endcase
        case (k)
          0, 1, 2, 3, 4, 5, 6: r_op = O_R;
          7: r_op = O_ADDIU; 8: r_op = O_ANDI; 9: r_op = O_ORI; 10: r_op = O_SLTI;
          11, 12: r_op = O_LW; 13, 14: r_op = O_SW; 15: r_op = O_BEQ; 16: r_op = O_BNE;
          17: r_op = O_BLTZ; 18: r_op = O_J; 19: r_op = O_HALT;
          default: r_op = O_BAD;
        endcase
      end
      step(r, r_op, r_fn, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
